z80_bus_mem: RTL and testbench

Parametrised synchronous memory and I/O responder for the tv80s bus. It holds a byte-wide memory and a separate I/O space, inserts a programmable number of wait states per access type, and records every committed CPU write in a trace FIFO that the bench drains to check memory side effects in order. It sits between the CPU core and the test harness and replaces ad-hoc memory arrays in per-instruction benches.

---
 rtl/z80_bus_mem.sv | 148 ++++++++++++++
 tb/tb_z80_bus_mem.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_mem.sv
// Memory and I/O responder for the tv80s bus: byte memory, I/O space, per-class wait states,
// and an ordered trace FIFO of every committed CPU write.
module z80_bus_mem #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned IO_ADDR_W   = 8,
  parameter int unsigned MEM_WAIT    = 0,
  parameter int unsigned IO_WAIT     = 0,
  parameter int unsigned TRACE_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [15:0]                   A,
  input  logic [7:0]                    dout,
  input  logic                          mreq_n,
  input  logic                          iorq_n,
  input  logic                          rd_n,
  input  logic                          wr_n,
  input  logic                          rfsh_n,
  input  logic                          m1_n,
  output logic [7:0]                    di,
  output logic                          wait_n,
  input  logic                          load_en,
  input  logic [ADDR_W-1:0]             load_addr,
  input  logic [7:0]                    load_data,
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic                          trace_is_io,
  output logic [15:0]                   trace_addr,
  output logic [7:0]                    trace_data,
  output logic [$clog2(TRACE_DEPTH):0]  trace_count,
  output logic                          trace_ovf
);

  localparam int unsigned PtrW = $clog2(TRACE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [3:0] MemWaitC = 4'(MEM_WAIT);
  localparam logic [3:0] IoWaitC  = 4'(IO_WAIT);

  logic [7:0]  mem_q [2**ADDR_W];
  logic [7:0]  io_q  [2**IO_ADDR_W];
  logic [24:0] fifo_q [TRACE_DEPTH];

  logic            mem_act, io_act, acc_act, start_mem, start_io, start;
  logic            mem_act_q, io_act_q;
  logic [3:0]      wcnt_q, wcnt_d, wcnt_eff;
  logic            commit, commit_q, commit_d;
  logic [7:0]      di_q, di_d;
  logic [24:0]     new_entry, head_q, head_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            full, push, pop;

  assign mem_act   = ~mreq_n & rfsh_n;
  assign io_act    = ~iorq_n & m1_n;
  assign acc_act   = mem_act | io_act;
  assign start_mem = mem_act & ~mem_act_q;
  assign start_io  = io_act & ~io_act_q;
  assign start     = start_mem | start_io;

  always_comb begin
    wcnt_eff = wcnt_q;
    wcnt_d   = wcnt_q;
    if (start) begin
      wcnt_eff = start_io ? IoWaitC : MemWaitC;
      wcnt_d   = wcnt_eff;
    end else if (wcnt_q != 4'd0) begin
      wcnt_d = wcnt_q - 4'd1;
    end
  end

  // rd_n high guards against committing on a conflicting read/write strobe pair.
  assign commit   = acc_act & ~wr_n & rd_n & (wcnt_eff == 4'd0) & (~commit_q | start);
  assign commit_d = acc_act & ((commit_q & ~start) | commit);

  assign new_entry  = {~mem_act, A, dout};
  assign di_d       = io_act ? io_q[A[IO_ADDR_W-1:0]] : mem_q[A[ADDR_W-1:0]];

  assign full       = cnt_q == CntW'(TRACE_DEPTH);
  assign pop        = (cnt_q != '0) & trace_ready;
  assign push       = commit & (~full | pop);
  assign rd_ptr_nxt = rd_ptr_q + PtrW'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | (commit & full & ~pop);
    head_d   = head_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_nxt;
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
    // Head is registered so it holds its last value once the FIFO drains.
    if (cnt_q == '0 || (pop && cnt_q == CntW'(1))) begin
      if (push) head_d = new_entry;
    end else if (pop) begin
      head_d = fifo_q[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_act_q <= 1'b0;
      io_act_q  <= 1'b0;
      wcnt_q    <= 4'd0;
      commit_q  <= 1'b0;
      di_q      <= 8'h00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      head_q    <= '0;
    end else begin
      mem_act_q <= mem_act;
      io_act_q  <= io_act;
      wcnt_q    <= wcnt_d;
      commit_q  <= commit_d;
      di_q      <= di_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      head_q    <= head_d;
    end
  end

  // Backdoor write is ordered last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (commit && mem_act)  mem_q[A[ADDR_W-1:0]] <= dout;
    if (commit && !mem_act) io_q[A[IO_ADDR_W-1:0]] <= dout;
    if (load_en)            mem_q[load_addr] <= load_data;
    if (push)               fifo_q[wr_ptr_q] <= new_entry;
  end

  assign di          = di_q;
  assign wait_n      = wcnt_q == 4'd0;
  assign trace_valid = cnt_q != '0;
  assign trace_count = cnt_q;
  assign trace_ovf   = ovf_q;
  assign trace_is_io = head_q[24];
  assign trace_addr  = head_q[23:8];
  assign trace_data  = head_q[7:0];

endmodule

// File: tb/tb_z80_bus_mem.sv
// Bench for z80_bus_mem: drives CPU bus cycles and checks against an array/queue model.
`timescale 1ns/1ps
module tb_z80_bus_mem;

  localparam int MW = 2;
  localparam int IW = 3;
  localparam int TD = 4;

  typedef struct packed {
    logic        is_io;
    logic [15:0] addr;
    logic [7:0]  data;
  } tr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] A = '0;
  logic [7:0]  dout = '0;
  logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1, m1_n = 1'b1;
  logic [7:0]  di;
  logic        wait_n;
  logic        load_en = 1'b0;
  logic [15:0] load_addr = '0;
  logic [7:0]  load_data = '0;
  logic        trace_valid, trace_ready = 1'b0, trace_is_io, trace_ovf;
  logic [15:0] trace_addr;
  logic [7:0]  trace_data;
  logic [2:0]  trace_count;

  z80_bus_mem #(
    .ADDR_W(16), .IO_ADDR_W(8), .MEM_WAIT(MW), .IO_WAIT(IW), .TRACE_DEPTH(TD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .dout(dout),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .m1_n(m1_n),
    .di(di), .wait_n(wait_n),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_is_io(trace_is_io),
    .trace_addr(trace_addr), .trace_data(trace_data), .trace_count(trace_count),
    .trace_ovf(trace_ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [7:0] mem_m [int];
  logic [7:0] io_m [int];
  tr_t        tq [$];
  bit         ovf_m = 1'b0;

  function automatic void model_commit(bit is_io, logic [15:0] addr, logic [7:0] data,
                                       bit popped);
    tr_t e;
    e = '{is_io: is_io, addr: addr, data: data};
    if (popped && tq.size() > 0) void'(tq.pop_front());
    if (tq.size() < TD) tq.push_back(e);
    else ovf_m = 1'b1;
    if (is_io) io_m[int'(addr[7:0])] = data;
    else mem_m[int'(addr)] = data;
  endfunction

  task automatic idle_bus();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1; m1_n = 1'b1;
  endtask

  task automatic backdoor(input logic [15:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = addr; load_data = data;
    @(posedge clk); #1;
    load_en = 1'b0;
    mem_m[int'(addr)] = data;
  endtask

  // One CPU bus cycle; optional trace pop and backdoor load land on the commit edge.
  task automatic bus_access(input bit is_io, input bit is_wr, input logic [15:0] addr,
                            input logic [7:0] data, input bit pop_at_commit, input bit bd_en,
                            input logic [15:0] bd_addr, input logic [7:0] bd_data,
                            input int hold, output int waits, output logic [7:0] rdata);
    @(posedge clk); #1;
    A = addr; dout = data; rd_n = is_wr; wr_n = 1'b1;
    if (is_io) iorq_n = 1'b0;
    else mreq_n = 1'b0;
    @(posedge clk); #1;
    if (is_wr) wr_n = 1'b0;
    waits = 0;
    while (wait_n === 1'b0 && waits < 40) begin
      waits++;
      @(posedge clk); #1;
    end
    if (pop_at_commit) trace_ready = 1'b1;
    if (bd_en) begin
      load_en = 1'b1; load_addr = bd_addr; load_data = bd_data;
    end
    @(posedge clk); #1;
    trace_ready = 1'b0; load_en = 1'b0;
    rdata = di;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic pop_head(output bit v, output tr_t e);
    v = trace_valid;
    e = '{is_io: trace_is_io, addr: trace_addr, data: trace_data};
    trace_ready = 1'b1;
    @(posedge clk); #1;
    trace_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (di !== 8'h00) begin errors++; $display("FAIL reset_di: got %h want 00", di); end
    checks++;
    if (wait_n !== 1'b1 || trace_valid !== 1'b0 || trace_count !== 3'd0 || trace_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: got wait_n=%b valid=%b count=%0d ovf=%b want 1 0 0 0",
               wait_n, trace_valid, trace_count, trace_ovf);
    end
    checks++;
    if ({trace_is_io, trace_addr, trace_data} !== 25'h0) begin
      errors++;
      $display("FAIL reset_head: got %h want 0", {trace_is_io, trace_addr, trace_data});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wait_n !== 1'b1 || trace_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset: got wait_n=%b valid=%b want 1 0", wait_n, trace_valid);
    end
  endtask

  task automatic test_push_ix();
    int w; logic [7:0] r; bit v; tr_t e, x;
    backdoor(16'h0000, 8'hdd);
    backdoor(16'h0001, 8'he5);
    for (int i = 0; i < 2; i++) begin
      bus_access(0, 0, 16'(i), 8'h00, 0, 0, 16'h0, 8'h0, 0, w, r);
      checks++;
      if (r !== mem_m[i] || w != MW) begin
        errors++; $display("FAIL opcode_fetch: got %h waits=%0d want %h waits=%0d", r, w, mem_m[i], MW);
      end
    end
    bus_access(0, 1, 16'h0760, 8'hb2, 0, 0, 16'h0, 8'h0, 0, w, r);
    model_commit(0, 16'h0760, 8'hb2, 0);
    bus_access(0, 1, 16'h075f, 8'h82, 0, 0, 16'h0, 8'h0, 1, w, r);
    model_commit(0, 16'h075f, 8'h82, 0);
    checks++;
    if (w != MW) begin errors++; $display("FAIL push_waits: got %0d want %0d", w, MW); end
    checks++;
    if (trace_count !== 3'(tq.size()) || trace_ovf !== ovf_m) begin
      errors++; $display("FAIL push_count: got %0d ovf=%b want %0d ovf=%b",
                         trace_count, trace_ovf, tq.size(), ovf_m);
    end
    while (tq.size() > 0) begin
      pop_head(v, e); x = tq.pop_front(); checks++;
      if (!v || e !== x) begin errors++; $display("FAIL push_trace: got v=%b %h want %h", v, e, x); end
    end
    bus_access(0, 0, 16'h075f, 8'h00, 0, 0, 16'h0, 8'h0, 0, w, r);
    checks++;
    if (r !== 8'h82) begin errors++; $display("FAIL push_mem_075f: got %h want 82", r); end
  endtask

  task automatic test_mem_read_refresh();
    int w, lows; logic [7:0] r, d; logic [15:0] a;
    a = 16'($urandom); d = 8'($urandom);
    backdoor(a, d);
    bus_access(0, 0, a, 8'h00, 0, 0, 16'h0, 8'h0, 0, w, r);
    checks++;
    if (w != MW || r !== d) begin
      errors++; $display("FAIL mem_read: got %h waits=%0d want %h waits=%0d", r, w, d, MW);
    end
    lows = 0;
    @(posedge clk); #1;
    mreq_n = 1'b0; rfsh_n = 1'b0; A = 16'($urandom);
    repeat (4) begin @(posedge clk); #1; if (wait_n !== 1'b1) lows++; end
    idle_bus();
    @(posedge clk); #1;
    iorq_n = 1'b0; m1_n = 1'b0; wr_n = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (wait_n !== 1'b1) lows++; end
    idle_bus();
    @(posedge clk); #1;
    checks++;
    if (lows != 0 || trace_count !== 3'd0) begin
      errors++; $display("FAIL refresh_inta: got wait-low cycles=%0d count=%0d want 0 0", lows, trace_count);
    end
  endtask

  task automatic test_io_out();
    int w; logic [7:0] r; bit v; tr_t e, x;
    backdoor(16'h3c5a, 8'h77);
    bus_access(1, 1, 16'h3c5a, 8'h3c, 0, 0, 16'h0, 8'h0, 0, w, r);
    model_commit(1, 16'h3c5a, 8'h3c, 0);
    checks++;
    if (w != IW) begin errors++; $display("FAIL io_waits: got %0d want %0d", w, IW); end
    pop_head(v, e); x = tq.pop_front(); checks++;
    if (!v || e !== x) begin errors++; $display("FAIL io_trace: got v=%b %h want %h", v, e, x); end
    bus_access(1, 0, 16'h005a, 8'h00, 0, 0, 16'h0, 8'h0, 0, w, r);
    checks++;
    if (r !== 8'h3c) begin errors++; $display("FAIL io_read: got %h want 3c", r); end
    bus_access(0, 0, 16'h3c5a, 8'h00, 0, 0, 16'h0, 8'h0, 0, w, r);
    checks++;
    if (r !== 8'h77) begin errors++; $display("FAIL io_mem_untouched: got %h want 77", r); end
  endtask

  task automatic test_random();
    logic [15:0] pool [8];
    int w, op; logic [7:0] r, d; logic [15:0] a; bit io, wr, v; tr_t e, x;
    for (int i = 0; i < 8; i++) pool[i] = 16'($urandom);
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 3));
      a  = pool[$urandom_range(0, 7)];
      d  = 8'($urandom);
      io = op >= 2;
      wr = (op % 2) == 0;
      bus_access(io, wr, a, d, 0, 0, 16'h0, 8'h0, int'($urandom_range(0, 2)), w, r);
      checks++;
      if (w != (io ? IW : MW)) begin
        errors++; $display("FAIL rand_waits: op=%0d got %0d want %0d", op, w, io ? IW : MW);
      end
      if (wr) begin
        model_commit(io, a, d, 0);
      end else if (io ? io_m.exists(int'(a[7:0])) : mem_m.exists(int'(a))) begin
        checks++;
        if (r !== (io ? io_m[int'(a[7:0])] : mem_m[int'(a)])) begin
          errors++; $display("FAIL rand_read: io=%b addr=%h got %h want %h", io, a, r,
                             io ? io_m[int'(a[7:0])] : mem_m[int'(a)]);
        end
      end
      if (tq.size() >= 3 || (tq.size() > 0 && $urandom_range(0, 3) == 0)) begin
        checks++;
        if (trace_count !== 3'(tq.size())) begin
          errors++; $display("FAIL rand_count: got %0d want %0d", trace_count, tq.size());
        end
        while (tq.size() > 0) begin
          pop_head(v, e); x = tq.pop_front(); checks++;
          if (!v || e !== x) begin errors++; $display("FAIL rand_trace: got v=%b %h want %h", v, e, x); end
        end
      end
    end
    while (tq.size() > 0) begin
      pop_head(v, e); x = tq.pop_front(); checks++;
      if (!v || e !== x) begin errors++; $display("FAIL rand_trace: got v=%b %h want %h", v, e, x); end
    end
  endtask

  task automatic test_overflow();
    int w; logic [7:0] r, d; bit v; tr_t e, x;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      bus_access(0, 1, 16'h4000 + 16'(i), d, 0, 0, 16'h0, 8'h0, 0, w, r);
      model_commit(0, 16'h4000 + 16'(i), d, 0);
    end
    checks++;
    if (trace_count !== 3'd4 || trace_ovf !== 1'b1 || !ovf_m) begin
      errors++; $display("FAIL ovf_fill: got count=%0d ovf=%b want 4 1", trace_count, trace_ovf);
    end
    d = 8'($urandom);
    bus_access(0, 1, 16'h4010, d, 1, 0, 16'h0, 8'h0, 0, w, r);
    model_commit(0, 16'h4010, d, 1);
    checks++;
    if (trace_count !== 3'd4 || trace_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_poppush: got count=%0d ovf=%b want 4 1", trace_count, trace_ovf);
    end
    while (tq.size() > 0) begin
      pop_head(v, e); x = tq.pop_front(); checks++;
      if (!v || e !== x) begin errors++; $display("FAIL ovf_trace: got v=%b %h want %h", v, e, x); end
    end
    checks++;
    if (trace_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got valid=%b want 0", trace_valid); end
  endtask

  task automatic test_backdoor_collision();
    int w; logic [7:0] r; bit v; tr_t e, x;
    bus_access(0, 1, 16'h1234, 8'h22, 0, 1, 16'h1234, 8'h11, 0, w, r);
    model_commit(0, 16'h1234, 8'h22, 0);
    mem_m[int'(16'h1234)] = 8'h11;
    pop_head(v, e); x = tq.pop_front(); checks++;
    if (!v || e !== x) begin errors++; $display("FAIL bd_trace: got v=%b %h want %h", v, e, x); end
    bus_access(0, 0, 16'h1234, 8'h00, 0, 0, 16'h0, 8'h0, 0, w, r);
    checks++;
    if (r !== mem_m[int'(16'h1234)]) begin
      errors++; $display("FAIL bd_mem: got %h want %h", r, mem_m[int'(16'h1234)]);
    end
  endtask

  task automatic test_reset_mid_wait();
    int w; logic [7:0] r;
    bus_access(0, 1, 16'h2222, 8'h5c, 0, 0, 16'h0, 8'h0, 0, w, r);
    model_commit(0, 16'h2222, 8'h5c, 0);
    @(posedge clk); #1;
    A = 16'h0042; iorq_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (wait_n !== 1'b0 || trace_count !== 3'(tq.size())) begin
      errors++; $display("FAIL pre_reset: got wait_n=%b count=%0d want 0 %0d", wait_n, trace_count, tq.size());
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (wait_n !== 1'b1) begin errors++; $display("FAIL async_reset_wait: got %b want 1", wait_n); end
    tq.delete(); ovf_m = 1'b0;
    idle_bus();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (trace_count !== 3'(tq.size()) || trace_ovf !== ovf_m || wait_n !== 1'b1) begin
      errors++; $display("FAIL post_mid_reset: got count=%0d ovf=%b wait_n=%b want 0 0 1",
                         trace_count, trace_ovf, wait_n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_push_ix();
    test_mem_read_refresh();
    test_io_out();
    test_random();
    test_overflow();
    test_backdoor_collision();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
